// File: rtl/da_pkg.sv
// Shared types, constants and the OBC slice encoder for the DA bit-slice feeder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: gen_state_e FSM states, T_W slice-index width, DA_K tap count,
//           obc_encode(bits) -> {A0, addr[DA_K-2:0]}.
package da_pkg;

  typedef enum logic {IDLE, SHIFT} gen_state_e;

  localparam int T_W  = 8;
  localparam int DA_K = 9;

  // Offset-binary coding: tap 0 picks the LUT half (kept as A0), every other
  // tap becomes an address bit that is 1 when it agrees with tap 0.
  function automatic logic [DA_K-1:0] obc_encode(input logic [DA_K-1:0] bits);
    logic [DA_K-1:0] enc;
    enc[DA_K-1] = bits[0];
    for (int i = 1; i < DA_K; i++) begin
      enc[i-1] = ~(bits[i] ^ bits[0]);
    end
    return enc;
  endfunction

endpackage

// File: rtl/da_obc_encode.sv
// Combinational OBC encoder for one bit slice across all taps.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: i_bits  - slice bit of each tap (bit i = tap i)
//        o_a0    - tap 0 bit
//        o_addr  - OBC address bits for taps 1..DA_K-1
module da_obc_encode
  import da_pkg::*;
(
  input  logic [DA_K-1:0] i_bits,
  output logic            o_a0,
  output logic [DA_K-2:0] o_addr
);

  logic [DA_K-1:0] w_enc;

  assign w_enc  = obc_encode(i_bits);
  assign o_a0   = w_enc[DA_K-1];
  assign o_addr = w_enc[DA_K-2:0];

endmodule

// File: rtl/da_bitslice_gen.sv
// Accepts a K-tap activation/weight vector and streams the activations LSB-first as OBC LUT addresses.
// Latency: accept at cycle n -> slice t=0 at n+1; frame spans n+1..n+DATA_WIDTH_A, no bubble between frames.
// Backpressure: in_ready only in IDLE and on the sign slice; source must hold A_in/B_in until accepted.
// Ports: clk/rst (async active-low), in_valid/in_ready handshake, A_in/B_in vector inputs,
//        gen_done slice valid, A0/addr_array OBC slice, t slice index, B_temp frame weights,
//        frame_last high with gen_done on the sign slice.
module da_bitslice_gen
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = 16,
  parameter int DATA_WIDTH_B = 16,
  parameter int K            = DA_K
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [K-1:0][DATA_WIDTH_A-1:0]   A_in,
  input  logic [K-1:0][DATA_WIDTH_B-1:0]   B_in,
  output logic                             gen_done,
  output logic                             A0,
  output logic [K-2:0]                     addr_array,
  output logic [T_W-1:0]                   t,
  output logic [K-1:0][DATA_WIDTH_B-1:0]   B_temp,
  output logic                             frame_last
);

  localparam logic [T_W-1:0] LAST_T = T_W'(DATA_WIDTH_A - 1);

  gen_state_e                     r_state;
  gen_state_e                     w_state_nxt;
  logic [K-1:0][DATA_WIDTH_A-1:0] r_sh;
  logic                           w_accept;
  logic                           w_load;
  logic                           w_adv;
  logic [T_W-1:0]                 w_t_nxt;
  logic [K-1:0]                   w_slice;
  logic                           w_a0;
  logic [K-2:0]                   w_addr;

  always_comb begin
    w_accept    = in_valid & in_ready;
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_t_nxt     = t;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_load      = 1'b1;
          w_t_nxt     = '0;
        end
      end
      SHIFT: begin
        if (t != LAST_T) begin
          w_adv   = 1'b1;
          w_t_nxt = t + T_W'(1);
        end else if (w_accept) begin
          // Back-to-back frame: restart at slice 0 on the same edge.
          w_load  = 1'b1;
          w_t_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slice 0 comes straight from the inputs on the accept edge; later slices
  // come from the LSBs of the shift registers, which were pre-shifted at load.
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < K; i++) begin
      w_slice[i] = w_load ? A_in[i][0] : r_sh[i][0];
    end
  end

  da_obc_encode u_obc (
    .i_bits (w_slice),
    .o_a0   (w_a0),
    .o_addr (w_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      in_ready   <= 1'b0;
      gen_done   <= 1'b0;
      A0         <= 1'b0;
      addr_array <= '0;
      t          <= '0;
      B_temp     <= '0;
      frame_last <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      gen_done <= (w_state_nxt == SHIFT);
      in_ready <= (w_state_nxt == IDLE) || (w_t_nxt == LAST_T);
      if (w_load) begin
        for (int i = 0; i < K; i++) begin
          r_sh[i] <= {1'b0, A_in[i][DATA_WIDTH_A-1:1]};
        end
        B_temp <= B_in;
      end else if (w_adv) begin
        for (int i = 0; i < K; i++) begin
          r_sh[i] <= {1'b0, r_sh[i][DATA_WIDTH_A-1:1]};
        end
      end
      // Slice outputs only move when a slice is produced; they hold while idle.
      if (w_load || w_adv) begin
        A0         <= w_a0;
        addr_array <= w_addr;
        t          <= w_t_nxt;
        frame_last <= (w_t_nxt == LAST_T);
      end
    end
  end

endmodule
